seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 21 ++
 rtl/seq_mul.sv | 62 ++++++
 rtl/seq_alu.sv | 131 +++++++++++++
 tb/tb_seq_alu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        FN_ADD = 3'd0,
        FN_SUB = 3'd1,
        FN_OR  = 3'd2,
        FN_AND = 3'd3,
        FN_XOR = 3'd4,
        FN_SHL = 3'd5,
        FN_SHR = 3'd6,
        FN_MUL = 3'd7
    } alu_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy;
    logic [2*WIDTH-1:0] step_acc;

    assign busy     = (cnt_q != '0);
    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    // product carries the final step combinationally so the caller can latch it on done.
    assign done    = busy && (cnt_q == CW'(1));
    assign product = step_acc;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
        end else if (busy) begin
            acc_d    = step_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative MUL, result held until consumed.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [2:0]       io_fn,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_result,
    output logic             io_zero,
    output logic             io_carry,
    output alu_state_e       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once valid is raised, it and the payload hold until that transfer.
    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     add_w;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   op_res;
    logic               op_carry;

    assign io_in_ready  = (state_q == ST_IDLE);
    assign io_out_valid = (state_q == ST_DONE);
    assign io_result    = result_q;
    assign io_zero      = zero_q;
    assign io_carry     = carry_q;
    assign dbg_state    = state_q;

    assign accept    = io_in_valid && io_in_ready;
    assign mul_start = accept && (alu_fn_e'(io_fn) == FN_MUL);
    assign add_w     = {1'b0, io_a} + {1'b0, io_b};
    assign shamt     = io_b[SHW-1:0];

    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        case (alu_fn_e'(io_fn))
            FN_ADD: begin
                op_res   = add_w[WIDTH-1:0];
                op_carry = add_w[WIDTH];
            end
            FN_SUB: begin
                op_res   = io_a - io_b;
                op_carry = (io_a < io_b);
            end
            FN_OR:   op_res = io_a | io_b;
            FN_AND:  op_res = io_a & io_b;
            FN_XOR:  op_res = io_a ^ io_b;
            FN_SHL:  op_res = io_a << shamt;
            FN_SHR:  op_res = io_a >> shamt;
            default: op_res = '0;
        endcase
    end

    seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (io_a),
        .b       (io_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (alu_fn_e'(io_fn) == FN_MUL) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        carry_d  = op_carry;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_product[WIDTH-1:0];
                    zero_d   = (mul_product[WIDTH-1:0] == '0);
                    carry_d  = |mul_product[2*WIDTH-1:WIDTH];
                end
            end
            ST_DONE: begin
                if (io_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: transaction-level model with per-cycle compare plus literal pin checks.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [2:0]   fn = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    alu_state_e   dbg_state;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: at most one outstanding op; result visible lat cycles after the accept cycle.
    bit             pending = 1'b0;
    int             cyc = 0;
    int             acc_cyc = 0;
    int             lat = 1;
    logic [W+1:0]   exp_q[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (in_valid),
        .io_in_ready  (in_ready),
        .io_fn        (fn),
        .io_a         (a),
        .io_b         (b),
        .io_out_valid (out_valid),
        .io_out_ready (out_ready),
        .io_result    (result),
        .io_zero      (zero),
        .io_carry     (carry),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] model_calc(logic [2:0] f, logic [W-1:0] x, logic [W-1:0] y);
        longint unsigned xa = x;
        longint unsigned yb = y;
        longint unsigned full;
        logic [W-1:0]    r = '0;
        logic            c = 1'b0;
        int              sh = int'(y) % W;
        case (f)
            3'd0: begin full = xa + yb; r = W'(full); c = (full >= (64'd1 << W)); end
            3'd1: begin r = x - y; c = (xa < yb); end
            3'd2: r = x | y;
            3'd3: r = x & y;
            3'd4: r = x ^ y;
            3'd5: r = x << sh;
            3'd6: r = x >> sh;
            default: begin full = xa * yb; r = W'(full); c = ((full >> W) != 0); end
        endcase
        return {c, (r == '0), r};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            pending = 1'b0;
            exp_q.delete();
        end else if (pending) begin
            if (cyc >= acc_cyc + lat - 1 && out_ready) begin
                pending = 1'b0;
                void'(exp_q.pop_front());
            end
        end else if (in_valid) begin
            exp_q.push_back(model_calc(fn, a, b));
            lat     = (fn == 3'd7) ? W + 1 : 1;
            acc_cyc = cyc + 1;
            pending = 1'b1;
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = pending && (cyc >= acc_cyc + lat - 1);
            chk("in_ready", 32'(in_ready), 32'(!pending));
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev && out_valid && exp_q.size() > 0) begin
                chk("result", 32'(result), 32'(exp_q[0][W-1:0]));
                chk("zero", 32'(zero), 32'(exp_q[0][W]));
                chk("carry", 32'(carry), 32'(exp_q[0][W+1]));
            end
        end
    end

    task automatic issue(logic [2:0] f, logic [W-1:0] x, logic [W-1:0] y);
        fn = f; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(int budget, bit garble, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (garble && i < 5) begin
                in_valid = 1'b1;
                fn = 3'($urandom_range(0, 7));
                a = W'($urandom);
                b = W'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                k = i;
                break;
            end
        end
        if (k < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_valid: got no io_out_valid expected one within %0d cycles", budget);
        end
    endtask

    task automatic finish_op();
        @(posedge clk); #1;
    endtask

    task automatic run_op(logic [2:0] f, logic [W-1:0] x, logic [W-1:0] y, output int k);
        issue(f, x, y);
        wait_valid(40, 1'b0, k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [2:0]   tf[6]  = '{3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
        logic [W-1:0] ta[6]  = '{8'hA5, 8'hA5, 8'h3C, 8'h00, 8'hF0, 8'hFF};
        logic [W-1:0] tb_[6] = '{8'h5A, 8'h5A, 8'h3C, 8'h00, 8'h0F, 8'h00};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_zero", 32'(zero), 32'h0);
        chk("rst_carry", 32'(carry), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        run_op(3'd0, 8'hF0, 8'h20, k);
        chk("add_lat", 32'(k), 32'd1);
        chk("add_res", 32'(result), 32'h10);
        chk("add_carry", 32'(carry), 32'h1);
        chk("add_zero", 32'(zero), 32'h0);
        finish_op();

        run_op(3'd1, 8'h05, 8'h05, k);
        chk("sub_eq_res", 32'(result), 32'h00);
        chk("sub_eq_zero", 32'(zero), 32'h1);
        chk("sub_eq_carry", 32'(carry), 32'h0);
        finish_op();

        run_op(3'd1, 8'h03, 8'h05, k);
        chk("sub_brw_res", 32'(result), 32'hFE);
        chk("sub_brw_carry", 32'(carry), 32'h1);
        finish_op();

        for (int i = 0; i < 6; i++) begin
            run_op(tf[i], ta[i], tb_[i], k);
            finish_op();
        end

        run_op(3'd5, 8'h5A, 8'h08, k);
        chk("shl0_res", 32'(result), 32'h5A);
        finish_op();

        run_op(3'd7, 8'h13, 8'h11, k);
        chk("mul1_lat", 32'(k), 32'd9);
        chk("mul1_res", 32'(result), 32'h43);
        chk("mul1_carry", 32'(carry), 32'h1);
        finish_op();

        issue(3'd7, 8'h0F, 8'h03);
        wait_valid(40, 1'b1, k);
        chk("mul2_lat", 32'(k), 32'd9);
        chk("mul2_res", 32'(result), 32'h2D);
        chk("mul2_carry", 32'(carry), 32'h0);
        finish_op();

        run_op(3'd6, 8'h80, 8'h0F, k);
        chk("shr_res", 32'(result), 32'h01);
        finish_op();

        out_ready = 1'b0;
        issue(3'd5, 8'h81, 8'h01);
        wait_valid(40, 1'b0, k);
        chk("bp_res0", 32'(result), 32'h02);
        chk("bp_ready0", 32'(in_ready), 32'h0);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res", 32'(result), 32'h02);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        finish_op();
        @(negedge clk);
        chk("bp_idle", 32'(in_ready), 32'h1);
        chk("bp_valid_drop", 32'(out_valid), 32'h0);

        issue(3'd7, 8'hC3, 8'h5D);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mul_valid", 32'(out_valid), 32'h0);
        chk("rst_mul_ready", 32'(in_ready), 32'h1);

        run_op(3'd4, 8'hAA, 8'hFF, k);
        chk("xor_res", 32'(result), 32'h55);
        finish_op();

        for (int i = 0; i < 12; i++) begin
            run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), k);
            finish_op();
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
